hop_lane_monitor: RTL
=====================

HOP_LANE_MONITOR -- requirements
Module: hop_lane_monitor

Interface
REQ-001 Parameters SHALL be:
- DEPTH, default 5, expected launch-to-arrival latency in cycles.
- TIMEOUT, default 15, maximum wait in cycles; TIMEOUT > DEPTH.
- CNT_W, default 8, width of the result counters.

REQ-002 Ports SHALL be:
- clock0, input, 1, sole clock; all logic on its rising edge.
- rst1, input, 1, reset; synchronous, active-high.
- launch, input, 1, pulse marking that start pulses were driven into all four hop lanes this cycle.
- lane_in, input, 4, downstream outputs of the four hop lanes; bit0..bit3 = lanes 1..4.
- clear, input, 1, synchronous clear of counters and sticky flags.
- busy, output, 1, high while a measurement is in progress.
- done, output, 1, one-cycle pulse when a measurement completes.
- pass, output, 1, result of the last measurement; valid from done onward.
- err_mask, output, 4, lanes that arrived late, early or not at all in the last measurement.
- timeout, output, 1, last measurement ended by TIMEOUT.
- pass_cnt, output, CNT_W, saturating count of passing measurements.
- fail_cnt, output, CNT_W, saturating count of failing measurements.
- ovr, output, 1, sticky; launch received while not IDLE.
- stray, output, 1, sticky; lane_in rising edge received while IDLE.

Function
REQ-003 The FSM SHALL have states IDLE, WAIT and DONE.

REQ-004 A lane arrival SHALL be a rising edge of lane_in[i]: the current sample is 1 and the previous-cycle sample, held in register lane_q, is 0. lane_q SHALL update every cycle.

REQ-005 IDLE + launch=1 SHALL:
- move the FSM to WAIT;
- set the latency counter lat to 1;
- clear the arrival mask arr and the per-lane first-arrival latencies.

REQ-006 In WAIT, lat SHALL increment by 1 per cycle. Arrival latency L(i) SHALL be the value of lat in the cycle lane i first arrives. An ideal DEPTH-stage chain whose start pulse coincides with launch yields L = DEPTH.

REQ-007 Only the first arrival per lane per measurement SHALL be recorded. Later edges on that lane SHALL be ignored.

REQ-008 WAIT SHALL exit to DONE in either case:
- all four arr bits are set, including the cycle in which the last bit sets;
- lat == TIMEOUT with any arr bit clear.

REQ-009 On entry to DONE, the outputs SHALL be registered as follows:
- err_mask[i] = 1 if lane i did not arrive or L(i) != DEPTH;
- pass = (err_mask == 0);
- timeout = 1 only for a TIMEOUT exit.

REQ-010 DONE SHALL last exactly one cycle, during which:
- done = 1;
- pass_cnt increments if pass = 1, otherwise fail_cnt increments;
- the FSM then returns to IDLE.

REQ-011 busy SHALL be 1 in WAIT and DONE and 0 in IDLE.

REQ-012 pass, err_mask and timeout SHALL hold their values until the next DONE.

REQ-013 Counters SHALL saturate at 2^CNT_W-1 and never wrap.

REQ-014 launch in WAIT or DONE SHALL be ignored for measurement and SHALL set ovr.

REQ-015 An arrival while in IDLE SHALL set stray. Arrivals in DONE SHALL be ignored.

REQ-016 clear=1 SHALL zero pass_cnt, fail_cnt, ovr and stray. The FSM and the last-result outputs SHALL be unaffected.

REQ-017 clear in the same cycle as DONE SHALL take priority: the counters read 0 afterwards.

REQ-018 An arrival in the same cycle as the launch that starts a measurement SHALL NOT be recorded for that measurement. It SHALL set stray.

Reset
REQ-019 When rst1 is sampled 1, all of the following SHALL be forced to 0 at that edge, overriding all other inputs: FSM (IDLE), lat, arr, lane_q, busy, done, pass, err_mask, timeout, pass_cnt, fail_cnt, ovr, stray.

REQ-020 rst1 asserted mid-measurement SHALL abort the measurement without a done pulse or any counter update.

REQ-021 The first cycle after rst1 deasserts SHALL accept launch normally.

Verification
REQ-022 Launch with all four lanes rising at lat=5 (defaults) -> done at the next cycle, pass=1, err_mask=0, timeout=0, pass_cnt=1.

REQ-023 Lane 3 rises at lat=6, the others at lat=5 -> pass=0, err_mask=4'b0100, fail_cnt=1.

REQ-024 Lane 1 never rises -> done after the lat=15 cycle, timeout=1, err_mask=4'b0001, fail_cnt=1.

REQ-025 Second launch at lat=3, plus lane 2 pulsed while IDLE -> ovr=1, stray=1, the first measurement is unaffected; a later clear -> ovr=0, stray=0, counters=0.

REQ-026 260 passing measurements with CNT_W=8 -> pass_cnt holds 255.

REQ-027 rst1 pulsed at lat=3 -> no done pulse, all outputs 0, and a launch on the next cycle measures normally.

Source files
------------

// File: rtl/hop_lane_monitor.sv
// Hop lane monitor: launches a measurement across four hop lanes and
// checks that each lane's first rising edge arrives exactly DEPTH cycles
// after launch; keeps results, saturating counters and sticky flags.
// Ports: clock0, rst1 (sync, active-high), launch, lane_in[3:0], clear,
//        busy, done, pass, err_mask[3:0], timeout, pass_cnt, fail_cnt,
//        ovr (launch while busy), stray (edge while idle).
module hop_lane_monitor #(
  parameter int DEPTH   = 5,
  parameter int TIMEOUT = 15,
  parameter int CNT_W   = 8
) (
  input  logic             clock0,
  input  logic             rst1,
  input  logic             launch,
  input  logic [3:0]       lane_in,
  input  logic             clear,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [3:0]       err_mask,
  output logic             timeout,
  output logic [CNT_W-1:0] pass_cnt,
  output logic [CNT_W-1:0] fail_cnt,
  output logic             ovr,
  output logic             stray
);

  localparam int LAT_W = $clog2(TIMEOUT + 1);
  localparam logic [LAT_W-1:0] DEPTH_L = LAT_W'(DEPTH);
  localparam logic [LAT_W-1:0] TMO_L   = LAT_W'(TIMEOUT);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_n;
  logic [LAT_W-1:0] lat;
  logic [3:0]       arr;
  logic [LAT_W-1:0] lat_a [4];
  logic [3:0]       lane_q;

  logic [3:0]       rise;
  logic [3:0]       new_arr;
  logic [3:0]       arr_n;
  logic             all_in;
  logic             tmo_hit;
  logic [3:0]       err_n;

  assign rise    = lane_in & ~lane_q;
  assign new_arr = (state == WAIT) ? (rise & ~arr) : 4'b0;
  assign arr_n   = arr | new_arr;
  assign all_in  = &arr_n;
  assign tmo_hit = (lat == TMO_L);

  assign busy = (state != IDLE);
  assign done = (state == DONE);

  // A lane arriving this very cycle uses the live lat value.
  always_comb begin
    err_n = 4'b0;
    for (int i = 0; i < 4; i++) begin
      if (!arr_n[i]) begin
        err_n[i] = 1'b1;
      end else if (new_arr[i]) begin
        err_n[i] = (lat != DEPTH_L);
      end else begin
        err_n[i] = (lat_a[i] != DEPTH_L);
      end
    end
  end

  always_ff @(posedge clock0) begin
    if (rst1) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE: if (launch) state_n = WAIT;
      WAIT: if (all_in || tmo_hit) state_n = DONE;
      DONE: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clock0) begin
    if (rst1) begin
      lat      <= '0;
      arr      <= '0;
      lane_q   <= '0;
      pass     <= 1'b0;
      err_mask <= '0;
      timeout  <= 1'b0;
      pass_cnt <= '0;
      fail_cnt <= '0;
      ovr      <= 1'b0;
      stray    <= 1'b0;
      for (int i = 0; i < 4; i++) lat_a[i] <= '0;
    end else begin
      lane_q <= lane_in;
      unique case (state)
        IDLE: begin
          if (launch) begin
            lat <= LAT_W'(1);
            arr <= '0;
            for (int i = 0; i < 4; i++) lat_a[i] <= '0;
          end
          if (|rise) stray <= 1'b1;
        end
        WAIT: begin
          arr <= arr_n;
          for (int i = 0; i < 4; i++) begin
            if (new_arr[i]) lat_a[i] <= lat;
          end
          if (state_n == DONE) begin
            err_mask <= err_n;
            pass     <= ~|err_n;
            timeout  <= ~all_in;
          end else begin
            lat <= lat + LAT_W'(1);
          end
          if (launch) ovr <= 1'b1;
        end
        DONE: begin
          if (pass) begin
            if (pass_cnt != '1) pass_cnt <= pass_cnt + 1'b1;
          end else begin
            if (fail_cnt != '1) fail_cnt <= fail_cnt + 1'b1;
          end
          if (launch) ovr <= 1'b1;
        end
        default: ;
      endcase
      // Clear wins over a same-cycle counter update.
      if (clear) begin
        pass_cnt <= '0;
        fail_cnt <= '0;
        ovr      <= 1'b0;
        stray    <= 1'b0;
      end
    end
  end

endmodule
